countdown_timer: RTL and testbench
==================================

Name: countdown_timer

Overview:
Loadable, prescaled down-counter/timer. It is the counting-down counterpart of the team's enabled up-counter. Software or top-level pins load a start value. The block then decrements it at a programmable rate and flags terminal count with a one-cycle pulse, in one-shot or auto-reload mode. It sits behind the top-level pin wrapper, which maps its ports onto the dedicated I/O.

Parameters:
WIDTH, 8, width of the count and load value
PRESCALE_W, 4, width of the prescale divider field

Ports:
clk  input  1  single clock; all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
enable  input  1  design-level count enable (not the tile ena); low freezes counting
load  input  1  load strobe; copies load_value into the reload register and the count
load_value  input  WIDTH  start/reload value
start  input  1  start or resume strobe
stop  input  1  pause strobe
auto_reload  input  1  1 = reload at terminal count and keep running; 0 = one-shot
prescale  input  PRESCALE_W  tick every prescale+1 enabled cycles
count  output  WIDTH  current count value (registered)
busy  output  1  high in RUN or PAUSE
tc_pulse  output  1  one-cycle pulse on terminal count (registered)
done  output  1  high in DONE state (one-shot finished)

Behaviour:
- Reset (rst_n low, asynchronous): count=0, reload_reg=0, prescaler=0, tc_pulse=0, done=0, busy=0, state=IDLE. Outputs hold these values until the first edge after rst_n rises.
- States: IDLE, RUN, PAUSE, DONE. busy = (RUN|PAUSE); done = (state==DONE).
- Priority per edge: load > start/stop > tick.
- load (any state): reload_reg<=load_value, count<=load_value, prescaler<=0, tc_pulse<=0, state<=IDLE. Aborts a run in progress.
- start:
  - From IDLE with count!=0: go to RUN, prescaler<=0.
  - From IDLE with count==0: go to DONE, tc_pulse<=1 for one cycle.
  - From DONE: count<=reload_reg, prescaler<=0, then RUN (or DONE plus tc_pulse if reload_reg==0).
  - From PAUSE: resume RUN; count and prescaler unchanged.
  - From RUN: ignored.
- stop: RUN->PAUSE, count and prescaler held; ignored in other states.
- start and stop asserted in the same cycle: no state change.
- Tick: in RUN with enable=1, when prescaler>=prescale, tick fires and prescaler<=0. Otherwise prescaler<=prescaler+1. With enable=0, the prescaler holds. The >= compare makes a mid-run reduction of prescale take effect on the next cycle.
- On a tick with count>1: count<=count-1.
- On a tick with count==1 (terminal):
  - tc_pulse<=1 on that edge, for exactly one cycle.
  - If auto_reload=1 and reload_reg!=0: count<=reload_reg, stay in RUN.
  - Otherwise: count<=0, state<=DONE.
  - auto_reload is sampled on the terminal tick only.
- tc_pulse is 0 on every edge without a terminal event.
- Latency: with prescale=P, the count steps every P+1 enabled cycles. A load of N reaches terminal after N*(P+1) enabled RUN cycles.
- count never wraps below 0. The arithmetic is unsigned WIDTH-bit.
- enable low in RUN: count and prescaler frozen, state stays RUN, busy stays 1.

Test Plan:
- Reset mid-run: load 5, start, assert rst_n low asynchronously between edges -> count=0, busy=0, done=0, tc_pulse=0 immediately.
- One-shot, prescale=0: load 3, start -> count 3,2,1,0 on consecutive edges. tc_pulse high on the cycle count becomes 0, then DONE with done=1, busy=0.
- Prescale/enable: prescale=2, load 2, start, enable toggled 1,0,1,1,1,1,1 -> decrements only after 3 enabled cycles each. Terminal reached after 6 enabled cycles.
- Auto-reload: auto_reload=1, load 2, prescale=0, start -> count sequence 2,1,2,1,2, with a tc_pulse each time it would reach 0. done never asserts.
- Pause/resume and simultaneous events:
  - stop at count=4 -> count holds 4 for 10 cycles, busy=1; start -> resumes at 3.
  - start and stop together in RUN -> no change.
  - load during RUN -> IDLE with the new value.
- Zero load: load 0, start -> DONE next edge, single tc_pulse, count stays 0. Start from DONE with reload_reg=0 behaves the same.

Source files
------------

// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with one-shot or auto-reload mode.
// Flags terminal count with a registered one-cycle tc_pulse.
module countdown_timer #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  enable,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_value,
  input  logic                  start,
  input  logic                  stop,
  input  logic                  auto_reload,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  busy,
  output logic                  tc_pulse,
  output logic                  done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                state, state_n;
  logic [WIDTH-1:0]      count_n;
  logic [WIDTH-1:0]      reload_reg, reload_n;
  logic [PRESCALE_W-1:0] psc, psc_n;
  logic                  tc_n;
  logic                  go, halt;

  assign go   = start & ~stop;
  assign halt = stop & ~start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      count      <= '0;
      reload_reg <= '0;
      psc        <= '0;
      tc_pulse   <= 1'b0;
    end else begin
      state      <= state_n;
      count      <= count_n;
      reload_reg <= reload_n;
      psc        <= psc_n;
      tc_pulse   <= tc_n;
    end
  end

  always_comb begin
    state_n  = state;
    count_n  = count;
    reload_n = reload_reg;
    psc_n    = psc;
    tc_n     = 1'b0;
    if (load) begin
      reload_n = load_value;
      count_n  = load_value;
      psc_n    = '0;
      state_n  = IDLE;
    end else if (go && state != RUN) begin
      unique case (state)
        IDLE: begin
          psc_n = '0;
          if (count != '0) begin
            state_n = RUN;
          end else begin
            state_n = DONE;
            tc_n    = 1'b1;
          end
        end
        DONE: begin
          count_n = reload_reg;
          psc_n   = '0;
          if (reload_reg != '0) begin
            state_n = RUN;
          end else begin
            state_n = DONE;
            tc_n    = 1'b1;
          end
        end
        PAUSE:   state_n = RUN;
        default: state_n = state;
      endcase
    end else if (halt && state == RUN) begin
      state_n = PAUSE;
    end else if (state == RUN && enable) begin
      if (psc >= prescale) begin
        psc_n = '0;
        if (count > WIDTH'(1)) begin
          count_n = count - WIDTH'(1);
        end else begin
          // count==0 cannot arise in RUN; treat it as a silent finish
          tc_n = (count == WIDTH'(1));
          if (auto_reload && reload_reg != '0 && tc_n) begin
            count_n = reload_reg;
          end else begin
            count_n = '0;
            state_n = DONE;
          end
        end
      end else begin
        psc_n = psc + PRESCALE_W'(1);
      end
    end
  end

  assign busy = (state == RUN) || (state == PAUSE);
  assign done = (state == DONE);

endmodule

// File: tb/tb_countdown_timer.sv
// Directed-vector bench for countdown_timer.
// Expected values are hand-derived cycle by cycle.
module tb_countdown_timer;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       stop;
  logic       auto_reload;
  logic [3:0] prescale;
  logic [7:0] count;
  logic       busy;
  logic       tc_pulse;
  logic       done;

  int vectors;
  int miscompares;

  countdown_timer #(.WIDTH(8), .PRESCALE_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .enable(enable),
    .load(load),
    .load_value(load_value),
    .start(start),
    .stop(stop),
    .auto_reload(auto_reload),
    .prescale(prescale),
    .count(count),
    .busy(busy),
    .tc_pulse(tc_pulse),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(input string tag, input logic [7:0] c,
                         input logic b, input logic t, input logic d);
    check({tag, ".count"}, 32'(count), 32'(c));
    check({tag, ".busy"}, 32'(busy), 32'(b));
    check({tag, ".tc"}, 32'(tc_pulse), 32'(t));
    check({tag, ".done"}, 32'(done), 32'(d));
  endtask

  task automatic do_load(input logic [7:0] v);
    load = 1'b1;
    load_value = v;
    step();
    load = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  logic [7:0] exp_c [7];
  logic       en_seq [7];

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_n = 1'b0;
    enable = 1'b1;
    load = 1'b0;
    load_value = '0;
    start = 1'b0;
    stop = 1'b0;
    auto_reload = 1'b0;
    prescale = '0;
    #12;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // reset asserted between edges during a run
    do_load(8'd5);
    do_start();
    step();
    chk_all("run_pre_rst", 8'd4, 1'b1, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk_all("async_rst", 8'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;

    // one-shot, prescale 0
    do_load(8'd3);
    chk_all("os_load", 8'd3, 1'b0, 1'b0, 1'b0);
    do_start();
    chk_all("os_start", 8'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("os_2", 8'd2, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("os_1", 8'd1, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("os_0", 8'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("os_after", 8'd0, 1'b0, 1'b0, 1'b1);
    do_start();
    chk_all("done_restart", 8'd3, 1'b1, 1'b0, 1'b0);

    // prescale 2 with enable gaps
    prescale = 4'd2;
    do_load(8'd2);
    do_start();
    exp_c = '{8'd2, 8'd2, 8'd2, 8'd1, 8'd1, 8'd1, 8'd0};
    en_seq = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 0; i < 7; i++) begin
      enable = en_seq[i];
      step();
      check($sformatf("psc_count%0d", i), 32'(count), 32'(exp_c[i]));
      check($sformatf("psc_tc%0d", i), 32'(tc_pulse), 32'(i == 6));
    end
    check("psc_done", 32'(done), 32'd1);
    enable = 1'b1;
    prescale = 4'd0;

    // auto-reload
    auto_reload = 1'b1;
    do_load(8'd2);
    do_start();
    exp_c = '{8'd1, 8'd2, 8'd1, 8'd2, 8'd1, 8'd2, 8'd1};
    for (int i = 0; i < 7; i++) begin
      step();
      check($sformatf("ar_count%0d", i), 32'(count), 32'(exp_c[i]));
      check($sformatf("ar_tc%0d", i), 32'(tc_pulse), 32'(i % 2 == 1));
      check($sformatf("ar_done%0d", i), 32'(done), 32'd0);
    end
    auto_reload = 1'b0;

    // pause / resume
    do_load(8'd6);
    do_start();
    step();
    step();
    chk_all("pre_stop", 8'd4, 1'b1, 1'b0, 1'b0);
    stop = 1'b1;
    step();
    stop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step();
      chk_all($sformatf("pause%0d", i), 8'd4, 1'b1, 1'b0, 1'b0);
    end
    do_start();
    chk_all("resume", 8'd4, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("resume_dec", 8'd3, 1'b1, 1'b0, 1'b0);

    // start+stop together, counting frozen by enable
    enable = 1'b0;
    start = 1'b1;
    stop = 1'b1;
    step();
    start = 1'b0;
    stop = 1'b0;
    chk_all("both", 8'd3, 1'b1, 1'b0, 1'b0);
    step();
    chk_all("frozen", 8'd3, 1'b1, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    chk_all("still_run", 8'd2, 1'b1, 1'b0, 1'b0);

    // load aborts run
    do_load(8'd9);
    chk_all("load_abort", 8'd9, 1'b0, 1'b0, 1'b0);
    step();
    chk_all("idle_hold", 8'd9, 1'b0, 1'b0, 1'b0);

    // zero load
    do_load(8'd0);
    do_start();
    chk_all("zero_start", 8'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("zero_after", 8'd0, 1'b0, 1'b0, 1'b1);
    do_start();
    chk_all("zero_restart", 8'd0, 1'b0, 1'b1, 1'b1);
    step();
    chk_all("zero_restart2", 8'd0, 1'b0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
